// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy CPU interrupt controller: IF/IE registers, IME state machine,
// dispatch vector latch and HALT wake logic.
module gb_cpu_interrupt_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] int_req,
    input  logic [7:0] data_i,
    input  logic       if_wr,
    input  logic       ie_wr,
    input  logic       enable_interrupts,
    input  logic       disable_interrupts,
    input  logic       reti_enable,
    input  logic       last_m_cycle,
    input  logic       write_interrupt_vector,
    input  logic       clear_interrupt_flag,
    input  logic       halt_req,
    output logic [7:0] if_o,
    output logic [7:0] ie_o,
    output logic       interrupt_queued,
    output logic [7:0] int_vector,
    output logic       ime_o,
    output logic       halted
);

    typedef enum logic [1:0] {
        IME_OFF      = 2'd0,
        IME_ARMED    = 2'd1,
        IME_ON       = 2'd2,
        IME_DISPATCH = 2'd3
    } ime_state_e;

    function automatic logic [2:0] lowest_idx(input logic [4:0] p);
        logic [2:0] idx;
        casez (p)
            5'b????1: idx = 3'd0;
            5'b???10: idx = 3'd1;
            5'b??100: idx = 3'd2;
            5'b?1000: idx = 3'd3;
            5'b10000: idx = 3'd4;
            default:  idx = 3'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [7:0] vector_of(input logic [4:0] p);
        logic [7:0] vec;
        if (p == 5'd0) begin
            vec = 8'h00;
        end else begin
            vec = 8'h40 + {2'b00, lowest_idx(p), 3'b000};
        end
        return vec;
    endfunction

    ime_state_e state_q, state_d;
    logic [4:0] if_q, if_d;
    logic [7:0] ie_q, ie_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] vec_q, vec_d;
    logic       halted_q, halted_d;
    logic [4:0] pending_s;
    logic [4:0] clr_mask_s;

    assign pending_s  = if_q & ie_q[4:0];
    assign clr_mask_s = 5'b00001 << idx_q;

    // IME state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IME_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // IME next state; DI has the final word over EI, RETI and dispatch
    always_comb begin
        state_d = state_q;
        case (state_q)
            IME_OFF: begin
                if (enable_interrupts) state_d = IME_ARMED;
                else                   state_d = IME_OFF;
            end
            IME_ARMED: begin
                if (last_m_cycle) state_d = IME_ON;
                else              state_d = IME_ARMED;
            end
            IME_ON: begin
                state_d = IME_ON;
            end
            IME_DISPATCH: begin
                if (clear_interrupt_flag) state_d = IME_OFF;
                else                      state_d = IME_DISPATCH;
            end
            default: begin
                state_d = IME_OFF;
            end
        endcase
        if (reti_enable && (state_q != IME_DISPATCH)) begin
            state_d = IME_ON;
        end else begin
            state_d = state_d;
        end
        if (write_interrupt_vector) begin
            state_d = IME_DISPATCH;
        end else begin
            state_d = state_d;
        end
        if (disable_interrupts) begin
            state_d = IME_OFF;
        end else begin
            state_d = state_d;
        end
    end

    // IME-derived outputs
    always_comb begin
        ime_o            = 1'b0;
        interrupt_queued = 1'b0;
        if (state_q == IME_ON) begin
            ime_o            = 1'b1;
            interrupt_queued = |pending_s;
        end else begin
            ime_o            = 1'b0;
            interrupt_queued = 1'b0;
        end
    end

    // Register next values; a zero vector marks a cancelled dispatch so the ack is a no-op
    always_comb begin
        if_d     = if_q;
        ie_d     = ie_q;
        idx_d    = idx_q;
        vec_d    = vec_q;
        halted_d = halted_q;
        if (if_wr) if_d = data_i[4:0];
        else       if_d = if_q;
        if (clear_interrupt_flag && (vec_q != 8'h00)) if_d = if_d & ~clr_mask_s;
        else                                          if_d = if_d;
        if_d = if_d | int_req;
        if (ie_wr) ie_d = data_i;
        else       ie_d = ie_q;
        if (write_interrupt_vector) begin
            idx_d = lowest_idx(pending_s);
            vec_d = vector_of(pending_s);
        end else begin
            idx_d = idx_q;
            vec_d = vec_q;
        end
        if (halted_q) begin
            halted_d = ~(|pending_s);
        end else if (halt_req) begin
            halted_d = ~(|pending_s);
        end else begin
            halted_d = 1'b0;
        end
    end

    // Data registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_q     <= 5'd0;
            ie_q     <= 8'h00;
            idx_q    <= 3'd0;
            vec_q    <= 8'h00;
            halted_q <= 1'b0;
        end else begin
            if_q     <= if_d;
            ie_q     <= ie_d;
            idx_q    <= idx_d;
            vec_q    <= vec_d;
            halted_q <= halted_d;
        end
    end

    assign if_o       = {3'b111, if_q};
    assign ie_o       = ie_q;
    assign int_vector = vec_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Scoreboard bench for gb_cpu_interrupt_ctrl: expectations are queued as stimulus
// is driven and compared just after the clock edge that should produce them.
module tb_gb_cpu_interrupt_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] int_req;
    logic [7:0] data_i;
    logic       if_wr, ie_wr;
    logic       enable_interrupts, disable_interrupts, reti_enable, last_m_cycle;
    logic       write_interrupt_vector, clear_interrupt_flag, halt_req;
    logic [7:0] if_o, ie_o, int_vector;
    logic       interrupt_queued, ime_o, halted;

    localparam int SEL_IF  = 0;
    localparam int SEL_IE  = 1;
    localparam int SEL_QUE = 2;
    localparam int SEL_VEC = 3;
    localparam int SEL_IME = 4;
    localparam int SEL_HLT = 5;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fails;

    gb_cpu_interrupt_ctrl dut (
        .clk                    (clk),
        .reset                  (reset),
        .int_req                (int_req),
        .data_i                 (data_i),
        .if_wr                  (if_wr),
        .ie_wr                  (ie_wr),
        .enable_interrupts      (enable_interrupts),
        .disable_interrupts     (disable_interrupts),
        .reti_enable            (reti_enable),
        .last_m_cycle           (last_m_cycle),
        .write_interrupt_vector (write_interrupt_vector),
        .clear_interrupt_flag   (clear_interrupt_flag),
        .halt_req               (halt_req),
        .if_o                   (if_o),
        .ie_o                   (ie_o),
        .interrupt_queued       (interrupt_queued),
        .int_vector             (int_vector),
        .ime_o                  (ime_o),
        .halted                 (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] observe(input int sel);
        logic [7:0] v;
        case (sel)
            SEL_IF:  v = if_o;
            SEL_IE:  v = ie_o;
            SEL_QUE: v = {7'd0, interrupt_queued};
            SEL_VEC: v = int_vector;
            SEL_IME: v = {7'd0, ime_o};
            SEL_HLT: v = {7'd0, halted};
            default: v = 8'hxx;
        endcase
        return v;
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic idle_inputs();
        int_req                = 5'd0;
        data_i                 = 8'h00;
        if_wr                  = 1'b0;
        ie_wr                  = 1'b0;
        enable_interrupts      = 1'b0;
        disable_interrupts     = 1'b0;
        reti_enable            = 1'b0;
        last_m_cycle           = 1'b0;
        write_interrupt_vector = 1'b0;
        clear_interrupt_flag   = 1'b0;
        halt_req               = 1'b0;
    endtask

    // apply the driven inputs at one posedge, then compare queued expectations
    task automatic cycle();
        @(posedge clk);
        #1;
        idle_inputs();
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle_inputs();
        reset = 1'b0;
        #2;
        expect_out("rst_if", SEL_IF, 8'hE0);
        expect_out("rst_ie", SEL_IE, 8'h00);
        expect_out("rst_que", SEL_QUE, 8'h00);
        expect_out("rst_ime", SEL_IME, 8'h00);
        expect_out("rst_vec", SEL_VEC, 8'h00);
        expect_out("rst_hlt", SEL_HLT, 8'h00);
        drain();
        @(negedge clk);
        reset = 1'b1;
        #1;

        // basic dispatch of VBlank with STAT-less mask 0x05
        ie_wr = 1'b1; data_i = 8'h05;
        expect_out("ie_wr", SEL_IE, 8'h05);
        cycle();
        reti_enable = 1'b1;
        expect_out("reti_on", SEL_IME, 8'h01);
        cycle();
        int_req = 5'h05;
        expect_out("req_if", SEL_IF, 8'hE5);
        expect_out("req_que", SEL_QUE, 8'h01);
        cycle();
        write_interrupt_vector = 1'b1;
        expect_out("vec_vblank", SEL_VEC, 8'h40);
        expect_out("disp_ime", SEL_IME, 8'h00);
        expect_out("disp_que", SEL_QUE, 8'h00);
        cycle();
        clear_interrupt_flag = 1'b1;
        expect_out("ack_if", SEL_IF, 8'hE4);
        expect_out("ack_ime", SEL_IME, 8'h00);
        cycle();
        if_wr = 1'b1; data_i = 8'h00; int_req = 5'h01;
        expect_out("set_beats_wr", SEL_IF, 8'hE1);
        cycle();
        if_wr = 1'b1; data_i = 8'h00;
        expect_out("if_clr", SEL_IF, 8'hE0);
        cycle();

        // EI delay across a two-cycle instruction
        enable_interrupts = 1'b1; last_m_cycle = 1'b1;
        expect_out("ei_delay0", SEL_IME, 8'h00);
        cycle();
        expect_out("ei_delay1", SEL_IME, 8'h00);
        cycle();
        last_m_cycle = 1'b1;
        expect_out("ei_on", SEL_IME, 8'h01);
        cycle();

        // DI beats EI, RETI re-enables immediately
        enable_interrupts = 1'b1; disable_interrupts = 1'b1;
        expect_out("ei_di_off", SEL_IME, 8'h00);
        cycle();
        reti_enable = 1'b1;
        expect_out("reti_only", SEL_IME, 8'h01);
        cycle();
        disable_interrupts = 1'b1; reti_enable = 1'b1;
        expect_out("di_beats_reti", SEL_IME, 8'h00);
        cycle();

        // cancelled dispatch: IE cleared before the vector is latched
        ie_wr = 1'b1; data_i = 8'h02; reti_enable = 1'b1;
        cycle();
        int_req = 5'h02;
        expect_out("stat_que", SEL_QUE, 8'h01);
        cycle();
        ie_wr = 1'b1; data_i = 8'h00;
        expect_out("ie0_que", SEL_QUE, 8'h00);
        cycle();
        write_interrupt_vector = 1'b1;
        expect_out("vec_cancel", SEL_VEC, 8'h00);
        cycle();
        clear_interrupt_flag = 1'b1;
        expect_out("cancel_if", SEL_IF, 8'hE2);
        expect_out("cancel_ime", SEL_IME, 8'h00);
        cycle();

        // priority: Serial over Joypad, vector holds, then Joypad
        ie_wr = 1'b1; if_wr = 1'b1; data_i = 8'h1F;
        cycle();
        if_wr = 1'b1; data_i = 8'h18;
        expect_out("prio_if", SEL_IF, 8'hF8);
        expect_out("prio_ie", SEL_IE, 8'h1F);
        cycle();
        write_interrupt_vector = 1'b1;
        expect_out("vec_serial", SEL_VEC, 8'h58);
        cycle();
        expect_out("vec_hold", SEL_VEC, 8'h58);
        cycle();
        clear_interrupt_flag = 1'b1;
        expect_out("ack_serial", SEL_IF, 8'hF0);
        cycle();
        write_interrupt_vector = 1'b1;
        expect_out("vec_joypad", SEL_VEC, 8'h60);
        cycle();
        clear_interrupt_flag = 1'b1;
        expect_out("ack_joypad", SEL_IF, 8'hE0);
        expect_out("ack_ime_off", SEL_IME, 8'h00);
        cycle();

        // HALT with IME off, woken by Timer
        ie_wr = 1'b1; data_i = 8'h04;
        cycle();
        halt_req = 1'b1;
        expect_out("halt_set", SEL_HLT, 8'h01);
        cycle();
        expect_out("halt_hold", SEL_HLT, 8'h01);
        cycle();
        int_req = 5'h04;
        expect_out("wake_if", SEL_IF, 8'hE4);
        cycle();
        expect_out("wake_hlt", SEL_HLT, 8'h00);
        expect_out("wake_que", SEL_QUE, 8'h00);
        expect_out("wake_if_kept", SEL_IF, 8'hE4);
        cycle();
        halt_req = 1'b1;
        expect_out("halt_pending", SEL_HLT, 8'h00);
        cycle();

        // request beats acknowledge on the same bit
        ie_wr = 1'b1; if_wr = 1'b1; data_i = 8'h02;
        cycle();
        write_interrupt_vector = 1'b1;
        expect_out("vec_stat", SEL_VEC, 8'h48);
        cycle();
        clear_interrupt_flag = 1'b1; int_req = 5'h02;
        expect_out("set_beats_ack", SEL_IF, 8'hE2);
        cycle();

        // asynchronous reset while dispatching
        write_interrupt_vector = 1'b1;
        expect_out("pre_rst_vec", SEL_VEC, 8'h48);
        cycle();
        #2;
        reset = 1'b0;
        #1;
        expect_out("arst_if", SEL_IF, 8'hE0);
        expect_out("arst_ie", SEL_IE, 8'h00);
        expect_out("arst_que", SEL_QUE, 8'h00);
        expect_out("arst_ime", SEL_IME, 8'h00);
        expect_out("arst_vec", SEL_VEC, 8'h00);
        expect_out("arst_hlt", SEL_HLT, 8'h00);
        drain();
        @(negedge clk);
        reset = 1'b1;
        clear_interrupt_flag = 1'b1;
        expect_out("post_rst_if", SEL_IF, 8'hE0);
        expect_out("post_rst_ime", SEL_IME, 8'h00);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
GB_CPU_INTERRUPT_CTRL -- requirements
Module: gb_cpu_interrupt_ctrl

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  machine (M) clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 int_req  input  5  per-source request pulses, bit0..4 = VBlank, STAT, Timer, Serial, Joypad.
REQ-005 data_i  input  8  CPU write data for IF/IE.
REQ-006 if_wr  input  1  write IF (0xFF0F) this cycle.
REQ-007 ie_wr  input  1  write IE (0xFFFF) this cycle.
REQ-008 enable_interrupts  input  1  EI executing this M-cycle.
REQ-009 disable_interrupts  input  1  DI executing this M-cycle.
REQ-010 reti_enable  input  1  RETI final cycle: immediate IME set.
REQ-011 last_m_cycle  input  1  current M-cycle ends an instruction.
REQ-012 write_interrupt_vector  input  1  ISR cycle that samples the vector.
REQ-013 clear_interrupt_flag  input  1  ISR cycle that acknowledges the latched source.
REQ-014 halt_req  input  1  HALT executing this M-cycle.
REQ-015 if_o  output  8  {3'b111, IF[4:0]}.
REQ-016 ie_o  output  8  IE[7:0].
REQ-017 interrupt_queued  output  1  dispatch to be taken at next instruction boundary.
REQ-018 int_vector  output  8  latched ISR target address low byte.
REQ-019 ime_o  output  1  IME state is ON.
REQ-020 halted  output  1  CPU is in HALT.

Function
REQ-021 pending[4:0] SHALL be IF[4:0] & IE[4:0]; IE[7:5] stored and read back, not used.
REQ-022 IF bit n SHALL set on int_req[n]; per bit, set beats if_wr data and beats clear_interrupt_flag in the same cycle.
REQ-023 if_wr SHALL load IF from data_i[4:0]; ie_wr SHALL load IE from data_i; both visible on outputs next cycle.
REQ-024 IME FSM states OFF, ARMED, ON, DISPATCH; ime_o = (state == ON).
REQ-025 OFF/ARMED -> ARMED on enable_interrupts; ARMED -> ON on a later cycle with last_m_cycle (one-instruction EI delay); EI while ON stays ON.
REQ-026 Any state except DISPATCH -> ON on reti_enable, with no delay.
REQ-027 disable_interrupts SHALL force OFF; DI beats EI and RETI in the same cycle.
REQ-028 interrupt_queued = (state == ON) & |pending, combinational from registered state; 0 in OFF/ARMED/DISPATCH.
REQ-029 write_interrupt_vector SHALL move state to DISPATCH and latch idx = lowest set bit of pending, with priority bit0 highest.
REQ-030 int_vector SHALL be 0x40 + 8*idx (0x40/0x48/0x50/0x58/0x60); if pending == 0 at latch, 0x00 (cancelled dispatch).
REQ-031 clear_interrupt_flag SHALL clear IF[idx] only, using the latched idx; no change if cancelled.
REQ-032 DISPATCH -> OFF on the cycle after clear_interrupt_flag (IME cleared by dispatch).
REQ-033 halt_req SHALL set halted next cycle if pending == 0; if pending != 0, halted stays 0.
REQ-034 While halted, |pending SHALL clear halted next cycle, independent of IME; IF is unchanged by the wake.
REQ-035 int_vector SHALL hold its value until the next write_interrupt_vector.

Reset
REQ-036 Reset assertion SHALL asynchronously force IF=0, IE=0, state=OFF, idx=0, int_vector=0x00, halted=0.
REQ-037 During reset, outputs SHALL be if_o=0xE0, ie_o=0x00, interrupt_queued=0, ime_o=0.
REQ-038 Reset mid-dispatch or mid-HALT SHALL abandon the operation; no IF bit is cleared by the reset release.
REQ-039 First state update SHALL occur on the first clk posedge after reset deasserts.

Verification
REQ-040 IE=0x05, IME ON, pulse int_req=0x05 -> interrupt_queued=1; write_interrupt_vector -> int_vector=0x40; clear_interrupt_flag -> if_o=0xE4, ime_o=0 one cycle later.
REQ-041 EI with last_m_cycle=1, then a 2-cycle NOP-type instruction -> ime_o=0 until that instruction's last_m_cycle edge, then 1.
REQ-042 EI and DI in the same cycle -> state OFF; RETI alone -> ime_o=1 next cycle.
REQ-043 ie_wr data 0x00 between write_interrupt_vector inputs, with pending cleared before latch -> int_vector=0x00, IF unchanged.
REQ-044 IME OFF, halt_req with pending=0 -> halted=1; int_req[2] with IE[2]=1 -> halted=0 next cycle, interrupt_queued=0.
REQ-045 int_req[1] and clear_interrupt_flag for idx=1 in the same cycle -> IF[1] remains 1; async reset mid-DISPATCH -> all REQ-037 values immediately.
